// File: rtl/reg_file.sv
// reg_file: 32-entry architectural register file with ROB rename tags, commit bypass and flush.
module reg_file #(
    parameter int ROB_ID_WIDTH = 5,
    parameter int XLEN         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    reset_from_rob_bus,
    input  logic                    valid_from_issuer,
    input  logic [4:0]              rd_from_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
    input  logic [4:0]              rs1_from_issuer,
    input  logic [4:0]              rs2_from_issuer,
    output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
    output logic [XLEN-1:0]         vj_to_issuer,
    output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
    output logic [XLEN-1:0]         vk_to_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
    input  logic [4:0]              rd_from_rob,
    input  logic [XLEN-1:0]         value_from_rob
);
    logic [XLEN-1:0]         regs_q [32];
    logic [XLEN-1:0]         regs_d [32];
    logic [ROB_ID_WIDTH-1:0] tag_q  [32];
    logic [ROB_ID_WIDTH-1:0] tag_d  [32];
    logic                    commit;
    logic                    byp_j;
    logic                    byp_k;
    always_comb begin
        commit = dest_from_rob != '0 && rd_from_rob != '0;
        byp_j  = commit && rd_from_rob == rs1_from_issuer && dest_from_rob == tag_q[rs1_from_issuer];
        byp_k  = commit && rd_from_rob == rs2_from_issuer && dest_from_rob == tag_q[rs2_from_issuer];
        qj_to_issuer = (rs1_from_issuer == '0 || byp_j) ? '0 : tag_q[rs1_from_issuer];
        vj_to_issuer = rs1_from_issuer == '0 ? '0 : byp_j ? value_from_rob : regs_q[rs1_from_issuer];
        qk_to_issuer = (rs2_from_issuer == '0 || byp_k) ? '0 : tag_q[rs2_from_issuer];
        vk_to_issuer = rs2_from_issuer == '0 ? '0 : byp_k ? value_from_rob : regs_q[rs2_from_issuer];
    end
    // commit clears the tag first so a same-cycle issue or flush overrides it
    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (commit) begin
                regs_d[rd_from_rob] = value_from_rob;
                if (tag_q[rd_from_rob] == dest_from_rob) tag_d[rd_from_rob] = '0;
            end
            if (reset_from_rob_bus) tag_d = '{default: '0};
            else if (valid_from_issuer && rd_from_issuer != '0) tag_d[rd_from_issuer] = dest_from_issuer;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            tag_q  <= '{default: '0};
        end else begin
            regs_q <= regs_d;
            tag_q  <= tag_d;
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plan plus randomized traffic against an array-based reference model.
module tb_reg_file;
    logic        clk = 0, rst = 0, rdy = 0, flush = 0, valid = 0;
    logic [4:0]  rd_i = 0, rs1 = 0, rs2 = 0, rd_r = 0;
    logic [4:0]  dest_i = 0, dest_r = 0, qj, qk;
    logic [31:0] vj, vk, val = 0;
    int          checks = 0, failures = 0;
    logic [31:0] m_regs [32];
    logic [4:0]  m_tag  [32];

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(flush),
        .valid_from_issuer(valid), .rd_from_issuer(rd_i), .dest_from_issuer(dest_i),
        .rs1_from_issuer(rs1), .rs2_from_issuer(rs2),
        .qj_to_issuer(qj), .vj_to_issuer(vj), .qk_to_issuer(qk), .vk_to_issuer(vk),
        .dest_from_rob(dest_r), .rd_from_rob(rd_r), .value_from_rob(val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [4:0] s);
        return s != 0 && dest_r != 0 && rd_r == s && dest_r == m_tag[s];
    endfunction

    function automatic logic [31:0] exp_q(input logic [4:0] s);
        return (s == 0 || hit(s)) ? 32'd0 : 32'(m_tag[s]);
    endfunction

    function automatic logic [31:0] exp_v(input logic [4:0] s);
        return s == 0 ? 32'd0 : hit(s) ? val : m_regs[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_tag[i]  = 0;
        end
    endtask

    task automatic model_edge();
        logic clr;
        clr = 0;
        if (!rdy) return;
        if (dest_r != 0 && rd_r != 0) begin
            m_regs[rd_r] = val;
            clr = m_tag[rd_r] == dest_r;
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) m_tag[i] = 0;
        end else begin
            if (clr) m_tag[rd_r] = 0;
            if (valid && rd_i != 0) m_tag[rd_i] = dest_i;
        end
    endtask

    task automatic tick();
        #1;
        check("qj", 32'(qj), exp_q(rs1));
        check("vj", vj, exp_v(rs1));
        check("qk", 32'(qk), exp_q(rs2));
        check("vk", vk, exp_v(rs2));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rdy = 1; valid = 0; flush = 0; dest_r = 0; rd_r = 0;
    endtask

    task automatic issue(input logic [4:0] r, input logic [4:0] d);
        idle(); valid = 1; rd_i = r; dest_i = d;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        idle(); rs1 = 5; rs2 = 6;
        #1 check("rst_q5", 32'(qj), 0); check("rst_v6", vk, 0);
        dest_r = 3; rd_r = 5; val = 32'hDEADBEEF;
        tick();
        idle(); #1 check("commit_v5", vj, 32'hDEADBEEF); check("commit_q5", 32'(qj), 0);
        tick();
        issue(7, 4); tick();
        idle(); rs1 = 7; #1 check("issue_q7", 32'(qj), 4);
        dest_r = 4; rd_r = 7; val = 32'h11;
        #1 check("bypass_q7", 32'(qj), 0); check("bypass_v7", vj, 32'h11);
        tick();
        idle(); #1 check("state_v7", vj, 32'h11); check("state_q7", 32'(qj), 0);
        tick();
        issue(9, 2); tick();
        issue(9, 5); tick();
        idle(); dest_r = 2; rd_r = 9; val = 32'h22; tick();
        idle(); rs1 = 9; #1 check("kept_q9", 32'(qj), 5); check("kept_v9", vj, 32'h22);
        tick();
        issue(10, 1); tick();
        issue(10, 6); dest_r = 1; rd_r = 10; val = 32'hAA; tick();
        idle(); rs1 = 10; #1 check("race_q10", 32'(qj), 6);
        tick();
        for (int r = 1; r < 32; r++) begin
            issue(5'(r), 5'((r - 1) % 16 + 1));
            tick();
        end
        issue(3, 8); flush = 1; dest_r = 4; rd_r = 4; val = 32'h44;
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            rs1 = 5'(2 * i); rs2 = 5'(2 * i + 1);
            #1 check("flush_qj", 32'(qj), 0); check("flush_qk", 32'(qk), 0);
            tick();
        end
        rs1 = 4; rs2 = 3;
        #1 check("flush_v4", vj, 32'h44); check("flush_q3", 32'(qk), 0);
        tick();
        issue(0, 7); dest_r = 7; rd_r = 0; val = 32'hFFFF; tick();
        idle(); rs1 = 0; rs2 = 0;
        #1 check("x0_q", 32'(qj), 0); check("x0_v", vk, 0);
        tick();
        issue(12, 9); tick();
        issue(12, 11); rdy = 0; flush = 1;
        repeat (3) tick();
        idle(); rs1 = 12; #1 check("stall_q12", 32'(qj), 9);
        tick();
        issue(10, 6); tick();
        idle(); rs1 = 4; rs2 = 10;
        @(posedge clk);
        #2 rst = 0;
        #1 check("arst_v4", vj, 0); check("arst_q10", 32'(qk), 0);
        model_reset();
        @(negedge clk);
        rst = 1;
        tick();
        for (int n = 0; n < 3000; n++) begin
            rdy    = $urandom_range(0, 99) < 85;
            flush  = $urandom_range(0, 99) < 3;
            valid  = $urandom_range(0, 1) == 1;
            rd_i   = 5'($urandom_range(0, 31));
            dest_i = 5'($urandom_range(1, 16));
            rs1    = 5'($urandom_range(0, 31));
            rs2    = $urandom_range(0, 3) == 0 ? rs1 : 5'($urandom_range(0, 31));
            rd_r   = $urandom_range(0, 1) == 1 ? rs1 : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: dest_r = 0;
                1: dest_r = m_tag[rd_r];
                default: dest_r = 5'($urandom_range(1, 16));
            endcase
            val = $urandom;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
